word_tx: RTL and testbench

Serial transmit stage of the logic analyzer, directly downstream of the main capture FSM. On a strobe it latches one WIDTH-bit word, either a RAM sample or a metadata/response word, and shifts it out as WIDTH/8 UART 8N1 frames, least significant byte first. Its ready flag paces the FSM's read-back loop, one word per handshake.

---
 rtl/logip_pkg.sv | 8 +
 rtl/uart_tx.sv | 66 ++++++
 rtl/word_tx.sv | 71 +++++++
 tb/tb_word_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// logip_pkg: shared FSM encodings and UART frame constants for the logic analyzer
package logip_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} word_st_e;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_st_e;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte serializer with registered line output
// ports: clk_i/rst_i clock and async reset, byte_i/byte_stb_i byte to send,
//        byte_done_o pulses in the last cycle of the stop bit, tx_o serial line
// A strobe in that last stop cycle chains straight into the next start bit.
module uart_tx
  import logip_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       byte_stb_i,
  output logic       byte_done_o,
  output logic       tx_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  byte_st_e st;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign byte_done_o = st == B_STOP && bit_end;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st <= B_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      tx_o <= STOP_BIT;
    end else begin
      cnt <= (st == B_IDLE || bit_end) ? '0 : cnt + CW'(1);
      case (st)
        B_IDLE, B_STOP: begin
          if ((st == B_IDLE || bit_end) && byte_stb_i) begin
            st <= B_START;
            sh <= byte_i;
            tx_o <= START_BIT;
          end else if (st == B_STOP && bit_end) begin
            st <= B_IDLE;
          end
        end
        B_START: begin
          if (bit_end) begin
            st <= B_DATA;
            tx_o <= sh[0];
          end
        end
        default: begin
          if (bit_end) begin
            sh <= sh >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              st <= B_STOP;
              bit_idx <= '0;
              tx_o <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o <= sh[1];
            end
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/word_tx.sv
// word_tx: latches one WIDTH-bit word and sends it as WIDTH/8 UART frames, LSB byte first
// ports: clk_i/rst_i clock and async reset, stb_i/sel_i accept strobe and source select,
//        ram_data_i/meta_data_i word sources, rdy_o idle/accepting, tx_o serial line
// Fixed overhead is one cycle per word: the SEND cycle between accept and the first
// start bit. Later bytes are handed over in the stop-bit done cycle so frames abut.
module word_tx
  import logip_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stb_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] ram_data_i,
  input  logic [WIDTH-1:0] meta_data_i,
  output logic             rdy_o,
  output logic             tx_o
);
  localparam int NB = WIDTH / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  word_st_e st;
  logic [WIDTH-1:0] sh;
  logic [IW-1:0] idx;
  logic byte_stb, byte_done, last;
  assign last = idx == IW'(NB - 1);
  assign byte_stb = st == SEND || (st == WAIT && byte_done && !last);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st <= IDLE;
      sh <= '0;
      idx <= '0;
      rdy_o <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (stb_i) begin
            sh <= sel_i ? ram_data_i : meta_data_i;
            idx <= '0;
            st <= SEND;
            rdy_o <= 1'b0;
          end
        end
        SEND: begin
          sh <= sh >> 8;
          st <= WAIT;
        end
        default: begin
          if (byte_done) begin
            if (last) begin
              st <= IDLE;
              rdy_o <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
              sh <= sh >> 8;
            end
          end
        end
      endcase
    end
  end
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .byte_i(sh[7:0]),
    .byte_stb_i(byte_stb),
    .byte_done_o(byte_done),
    .tx_o(tx_o)
  );
endmodule

// File: tb/tb_word_tx.sv
// tb_word_tx: directed vectors for word_tx at 4 and 1 clocks per bit
module tb_word_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4, stb4, sel4, rdy4, tx4;
  logic [31:0] ram4, meta4;
  logic rst1, stb1, sel1, rdy1, tx1;
  logic [31:0] ram1, meta1;
  word_tx #(.WIDTH(32), .CLKS_PER_BIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .stb_i(stb4), .sel_i(sel4),
    .ram_data_i(ram4), .meta_data_i(meta4), .rdy_o(rdy4), .tx_o(tx4)
  );
  word_tx #(.WIDTH(32), .CLKS_PER_BIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .stb_i(stb1), .sel_i(sel1),
    .ram_data_i(ram1), .meta_data_i(meta1), .rdy_o(rdy1), .tx_o(tx1)
  );
  typedef struct {
    logic sel;
    logic [31:0] ram;
    logic [31:0] meta;
    logic [31:0] exp;
    logic busy;
    logic b2b;
  } vec_t;
  vec_t vecs[5];
  int checks = 0, errors = 0, cyc = 0, last_stop = -100;
  logic s[0:199];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask
  function automatic logic [8:0] decode(input int off, input int c);
    logic ok;
    logic e;
    logic [7:0] b;
    ok = 1'b1;
    b = '0;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : s[off + k * c];
      if (k > 0 && k < 9) b[k-1] = e;
      for (int j = 0; j < c; j++) if (s[off + k * c + j] !== e) ok = 1'b0;
    end
    return {ok, b};
  endfunction
  task automatic run_word(input vec_t v, input int n);
    int lat, low, bad;
    logic [8:0] d;
    lat = 0;
    low = 0;
    for (int i = 0; i < 400 && rdy4 !== 1'b1; i++) tick();
    check($sformatf("v%0d ready", n), {31'd0, rdy4}, 32'd1);
    sel4 = v.sel;
    ram4 = v.ram;
    meta4 = v.meta;
    stb4 = 1'b1;
    do begin
      tick();
      stb4 = 1'b0;
      lat++;
      if (rdy4 !== 1'b1) low++;
    end while (tx4 === 1'b1 && lat < 4);
    check_rng($sformatf("v%0d start latency", n), lat, 1, 2);
    if (v.b2b) check_rng($sformatf("v%0d b2b gap", n), cyc - last_stop - 1, 0, 2);
    s[0] = tx4;
    for (int i = 1; i < 160; i++) begin
      tick();
      s[i] = tx4;
      if (rdy4 !== 1'b1) low++;
      if (v.busy && i == 50) begin
        sel4 = 1'b1;
        ram4 = 32'hDEADBEEF;
        stb4 = 1'b1;
      end
      if (i == 51) stb4 = 1'b0;
    end
    last_stop = cyc;
    for (int k = 0; k < 4; k++) begin
      d = decode(40 * k, 4);
      check($sformatf("v%0d frame%0d shape", n, k), {31'd0, d[8]}, 32'd1);
      check($sformatf("v%0d byte%0d", n, k), {24'd0, d[7:0]}, {24'd0, v.exp[8*k +: 8]});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rdy4 === 1'b1) break;
      low++;
    end
    check_rng($sformatf("v%0d rdy low cycles", n), low, 160, 162);
    if (v.busy) begin
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (tx4 !== 1'b1 || rdy4 !== 1'b1) bad++;
      end
      check($sformatf("v%0d busy strobe ignored", n), bad, 0);
    end
  endtask
  initial begin
    logic [8:0] d;
    int bad, w;
    vecs[0] = '{1'b1, 32'h44332211, 32'h00000000, 32'h44332211, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h534C4131, 32'h534C4131, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000A5C3, 32'h12345678, 32'h0000A5C3, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h000000FF, 32'h00000000, 32'h000000FF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h00000000, 32'hFF000000, 32'hFF000000, 1'b0, 1'b1};
    rst4 = 1'b0; stb4 = 1'b0; sel4 = 1'b0; ram4 = '0; meta4 = '0;
    rst1 = 1'b0; stb1 = 1'b0; sel1 = 1'b0; ram1 = '0; meta1 = '0;
    #1;
    rst4 = 1'b1;
    rst1 = 1'b1;
    #1;
    check("reset rdy4", {31'd0, rdy4}, 32'd1);
    check("reset tx4", {31'd0, tx4}, 32'd1);
    check("reset rdy1", {31'd0, rdy1}, 32'd1);
    check("reset tx1", {31'd0, tx1}, 32'd1);
    repeat (3) tick();
    rst4 = 1'b0;
    rst1 = 1'b0;
    tick();
    for (int n = 0; n < 5; n++) run_word(vecs[n], n);
    sel4 = 1'b1;
    ram4 = 32'h00000000;
    stb4 = 1'b1;
    tick();
    stb4 = 1'b0;
    for (int i = 0; i < 4 && tx4 === 1'b1; i++) tick();
    repeat (10) tick();
    check("pre-reset tx4 low", {31'd0, tx4}, 32'd0);
    #1 rst4 = 1'b1;
    #1;
    check("async reset tx4", {31'd0, tx4}, 32'd1);
    check("async reset rdy4", {31'd0, rdy4}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx4 !== 1'b1 || rdy4 !== 1'b1) bad++;
    end
    check("reset hold quiet", bad, 0);
    rst4 = 1'b0;
    tick();
    sel1 = 1'b1;
    ram1 = 32'h12345678;
    stb1 = 1'b1;
    tick();
    stb1 = 1'b0;
    for (int i = 0; i < 4 && tx1 === 1'b1; i++) tick();
    repeat (22) tick();
    check("c1 pre-reset tx low", {31'd0, tx1}, 32'd0);
    check("c1 pre-reset busy", {31'd0, rdy1}, 32'd0);
    #1 rst1 = 1'b1;
    #1;
    check("c1 async reset tx1", {31'd0, tx1}, 32'd1);
    check("c1 async reset rdy1", {31'd0, rdy1}, 32'd1);
    repeat (3) tick();
    rst1 = 1'b0;
    tick();
    ram1 = 32'h000000A5;
    stb1 = 1'b1;
    tick();
    stb1 = 1'b0;
    w = 1;
    while (tx1 === 1'b1 && w < 4) begin
      tick();
      w++;
    end
    check_rng("c1 start latency", w, 1, 2);
    s[0] = tx1;
    for (int i = 1; i < 10; i++) begin
      tick();
      s[i] = tx1;
    end
    d = decode(0, 1);
    check("c1 frame shape", {31'd0, d[8]}, 32'd1);
    check("c1 first byte", {24'd0, d[7:0]}, 32'h000000A5);
    for (int i = 0; i < 100 && rdy1 !== 1'b1; i++) tick();
    check("c1 ready return", {31'd0, rdy1}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
